// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle; SEQ_CHUNK_ADDER_SAT_EN clamps s on signed overflow.
// Latency: out_valid rises NCH cycles after the accept edge; one operation in flight (II = NCH+2).
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  generate
    if (CHUNK <= 0 || (WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0) begin : g_param_chk
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] opa, opb, acc, res_full, s_nxt;
  logic             carry;
  logic [CHUNK-1:0] ach, bch;
  logic [CHUNK:0]   csum;
  logic             c_msb, ov_nxt, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // in_ready/out_valid depend only on the registered state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (k == KLAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ach    = opa[k*CHUNK +: CHUNK];
    bch    = opb[k*CHUNK +: CHUNK];
    csum   = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
    // carry into the chunk's top bit, recovered from the sum bit
    c_msb  = csum[CHUNK-1] ^ ach[CHUNK-1] ^ bch[CHUNK-1];
    ov_nxt = c_msb ^ csum[CHUNK];
    last   = (state == RUN) && (k == KLAST);
    res_full = acc;
    res_full[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    // clamp toward the sign of a; valid for add and subtract alike
    if (ov_nxt) s_nxt = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else        s_nxt = res_full;
`else
    s_nxt = res_full;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            k     <= '0;
          end
        end
        RUN: begin
          acc[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          carry <= csum[CHUNK];
          k     <= k + KW'(1);
          if (last) begin
            s        <= s_nxt;
            cout     <= csum[CHUNK];
            overflow <= ov_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: 32/8 instance plus an 8/8 instance.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        cin, sub, cout, overflow;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, s8;
  logic        cin8, sub8, co8, of8;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .overflow(overflow)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8),
    .out_ready(or8), .s(s8), .cout(co8), .overflow(of8)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ov;
  } res_t;

  res_t q[$];
  res_t last_exp;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ovp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on a full-width integer sum
  function automatic res_t model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                 input logic ci, input logic sb);
    logic [63:0] mask, bb, tot, sv;
    logic        as, bs;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    bb   = (sb ? ~bi : bi) & mask;
    tot  = (ai & mask) + bb + {63'd0, ci ^ sb};
    sv   = tot & mask;
    as   = ai[w-1];
    bs   = bb[w-1];
    r.cout = tot[w];
    r.ov   = (as == bs) && (sv[w-1] != as);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    if (r.ov) sv = as ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    r.s = sv[31:0];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc <= cyc + 1;
  end

  // Output monitor: compare every DONE cycle, pop on handshake
  always @(negedge clk) begin
    if (out_valid) begin
      if (!ovp) chk("latency", 64'(cyc - acc_cyc), 64'd4);
      chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      if (q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        chk("s", {32'd0, s}, {32'd0, q[0].s});
        chk("cout", {63'd0, cout}, {63'd0, q[0].cout});
        chk("overflow", {63'd0, overflow}, {63'd0, q[0].ov});
        if (out_ready) void'(q.pop_front());
      end
    end
    ovp <= out_valid;
  end

  task automatic send(input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic sb);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    a = ai; b = bi; cin = ci; sub = sb; in_valid = 1'b1;
    last_exp = model(32, {32'd0, ai}, {32'd0, bi}, ci, sb);
    q.push_back(last_exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    res_t r8;
    int   t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_s", {32'd0, s}, 64'd0);
    chk("rst_flags", {62'd0, cout, overflow}, 64'd0);
    chk("rst8_ready_valid", {62'd0, ir8, ov8}, 64'd2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0); drain();
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); drain();

    // Result held in DONE with new operands presented
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("no_accept_after_hold", {63'd0, in_ready}, 64'd1);

    send(32'd5, 32'd7, 1'b0, 1'b1); drain();
    send(32'h80000000, 32'd1, 1'b0, 1'b1); drain();
    repeat (2) @(posedge clk);
    #1;
    chk("s_hold_idle", {32'd0, s}, {32'd0, last_exp.s});

    // Reset during chunk 2 discards the operation
    send(32'h12345678, 32'h00001111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_s", {32'd0, s}, 64'd0);
    chk("midrst_flags", {62'd0, cout, overflow}, 64'd0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd3, 32'd4, 1'b0, 1'b0); drain();

    for (int i = 0; i < 6; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Single-chunk instance
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b0; iv8 = 1'b1;
    r8 = model(8, 64'h80, 64'h80, 1'b0, 1'b0);
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("d8_valid_early", {63'd0, ov8}, 64'd0);
    @(posedge clk); #1;
    chk("d8_valid", {63'd0, ov8}, 64'd1);
    chk("d8_s", {56'd0, s8}, {56'd0, r8.s[7:0]});
    chk("d8_cout", {63'd0, co8}, {63'd0, r8.cout});
    chk("d8_ovf", {63'd0, of8}, {63'd0, r8.ov});
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("d8_after_hs", {62'd0, ir8, ov8}, 64'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
